// File: rtl/kbd_pia_fifo_if.sv
// Keyboard PIA bus bundle: CPU register-pair access plus the upstream key-byte stream.
interface kbd_pia_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_clken;
  logic          cs;
  logic          we;
  logic          address;
  logic [7:0]    dout;
  logic          key_valid;
  logic [7:0]    key_data;
  logic          flush;
  logic          key_ready;
  logic          overflow;
  logic [CW-1:0] count;

  modport master (
    output cpu_clken, cs, we, address, key_valid, key_data, flush,
    input  dout, key_ready, overflow, count
  );

  modport slave (
    input  cpu_clken, cs, we, address, key_valid, key_data, flush,
    output dout, key_ready, overflow, count
  );
endinterface

// File: rtl/kbd_pia_fifo.sv
// Apple-1 style KBD/KBDCR register pair fronted by a small FIFO of 7-bit uppercased keys.
module kbd_pia_fifo #(
  parameter int DEPTH = 8
) (
  input  logic          clk25,
  input  logic          rst,
  kbd_pia_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [7:0]    dout_q;

  logic rd_kbd, rd_cr, empty, full, pop, push, drop;
  logic [6:0] key_up;

  always_comb begin
    rd_kbd = bus.cpu_clken & bus.cs & ~bus.we & ~bus.address;
    rd_cr  = bus.cpu_clken & bus.cs & ~bus.we &  bus.address;
    empty  = (count_q == '0);
    full   = (count_q == CW'(DEPTH));
    pop    = rd_kbd & ~empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    push   = bus.key_valid & (~full | pop);
    drop   = bus.key_valid & full & ~pop;
    key_up = bus.key_data[6:0];
    if (key_up >= 7'h61 && key_up <= 7'h7A)
      key_up = key_up - 7'h20;
  end

  always_ff @(posedge clk25) begin
    if (push && !bus.flush)
      mem[wr_ptr] <= key_up;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);

      if (drop)       ovf_q <= 1'b1;
      else if (rd_cr) ovf_q <= 1'b0;

      if (pop)         dout_q <= {1'b1, mem[rd_ptr]};
      else if (rd_kbd) dout_q <= 8'h80;
      else if (rd_cr)  dout_q <= {~empty, 5'b0, ovf_q, full};
    end
  end

  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.key_ready = ~full;
endmodule

// File: tb/tb_kbd_pia_fifo.sv
// Directed bench for kbd_pia_fifo: register reads, FIFO order, overflow, flush and reset.
module tb_kbd_pia_fifo;
  localparam int DEPTH = 8;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  kbd_pia_fifo_if #(.DEPTH(DEPTH)) bus ();
  kbd_pia_fifo #(.DEPTH(DEPTH)) dut (.clk25(clk25), .rst(rst), .bus(bus));

  always #20 clk25 = ~clk25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.key_valid = 1'b1; bus.key_data = b;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic access(input logic clken, input logic w, input logic a);
    bus.cpu_clken = clken; bus.cs = 1'b1; bus.we = w; bus.address = a;
    tick();
    bus.cpu_clken = 1'b0; bus.cs = 1'b0; bus.we = 1'b0; bus.address = 1'b0;
  endtask

  task automatic kbd_read(); access(1'b1, 1'b0, 1'b0); endtask
  task automatic cr_read();  access(1'b1, 1'b0, 1'b1); endtask

  initial begin
    bus.cpu_clken = 0; bus.cs = 0; bus.we = 0; bus.address = 0;
    bus.key_valid = 0; bus.key_data = 0; bus.flush = 0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_dout", 32'(bus.dout), 32'h00);
    chk("rst_ovf", 32'(bus.overflow), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.key_ready), 1);
    cr_read();
    chk("cr_after_rst", 32'(bus.dout), 32'h00);

    // lowercase 'a' comes out as 'A' with bit 7 set
    push(8'h61);
    cr_read();
    chk("cr_one_entry", 32'(bus.dout), 32'h80);
    kbd_read();
    chk("read_a", 32'(bus.dout), 32'hC1);
    chk("count_after_a", 32'(bus.count), 0);

    // overfill by one
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
    chk("full_count", 32'(bus.count), 8);
    chk("full_ready", 32'(bus.key_ready), 0);
    chk("full_ovf", 32'(bus.overflow), 1);
    cr_read();
    chk("cr_full", 32'(bus.dout), 32'h83);
    chk("ovf_cleared", 32'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) begin
      kbd_read();
      chk($sformatf("drain_%0d", i), 32'(bus.dout), 32'hB1 + 32'(i));
    end
    cr_read();
    chk("cr_drained", 32'(bus.dout), 32'h00);

    // pop and push together on an empty FIFO
    bus.key_valid = 1'b1; bus.key_data = 8'h0D;
    kbd_read();
    bus.key_valid = 1'b0;
    chk("empty_pp_dout", 32'(bus.dout), 32'h80);
    chk("empty_pp_count", 32'(bus.count), 1);
    kbd_read();
    chk("empty_pp_next", 32'(bus.dout), 32'h8D);

    // pop and push together on a full FIFO
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    bus.key_valid = 1'b1; bus.key_data = 8'h41;
    kbd_read();
    bus.key_valid = 1'b0;
    chk("full_pp_dout", 32'(bus.dout), 32'hD0);
    chk("full_pp_ovf", 32'(bus.overflow), 0);
    chk("full_pp_count", 32'(bus.count), 8);
    for (int i = 1; i < 8; i++) begin
      kbd_read();
      chk($sformatf("full_pp_drain_%0d", i), 32'(bus.dout), 32'hD0 + 32'(i));
    end
    kbd_read();
    chk("full_pp_last", 32'(bus.dout), 32'hC1);
    chk("full_pp_empty", 32'(bus.count), 0);

    // gated reads, writes, flush
    push(8'h01); push(8'h02); push(8'h03);
    kbd_read();
    chk("pre_gate_dout", 32'(bus.dout), 32'h81);
    access(1'b0, 1'b0, 1'b0);
    chk("noclken_dout", 32'(bus.dout), 32'h81);
    chk("noclken_count", 32'(bus.count), 2);
    access(1'b0, 1'b0, 1'b1);
    chk("noclken_cr_dout", 32'(bus.dout), 32'h81);
    access(1'b1, 1'b1, 1'b0);
    chk("write_dout", 32'(bus.dout), 32'h81);
    chk("write_count", 32'(bus.count), 2);
    push(8'h04);
    chk("preflush_count", 32'(bus.count), 3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_ovf", 32'(bus.overflow), 0);
    chk("flush_dout", 32'(bus.dout), 32'h81);
    kbd_read();
    chk("flush_empty_read", 32'(bus.dout), 32'h80);

    // case-fold boundaries and bit 7 ignored
    push(8'h7A); push(8'hE1); push(8'h7B); push(8'h60);
    kbd_read(); chk("fold_z", 32'(bus.dout), 32'hDA);
    kbd_read(); chk("bit7_a", 32'(bus.dout), 32'hC1);
    kbd_read(); chk("brace", 32'(bus.dout), 32'hFB);
    kbd_read(); chk("backtick", 32'(bus.dout), 32'hE0);

    // reset mid-operation is immediate
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    kbd_read();
    chk("pre_rst_dout", 32'(bus.dout), 32'hA1);
    chk("pre_rst_count", 32'(bus.count), 5);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_dout", 32'(bus.dout), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    cr_read();
    chk("post_rst_cr", 32'(bus.dout), 32'h00);
    kbd_read();
    chk("post_rst_read", 32'(bus.dout), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kbd_pia_fifo.md
KBD_PIA_FIFO -- requirements
Module: kbd_pia_fifo

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entry count; legal values are powers of two from 2 to 64.
REQ-002 clk25  input  1  25 MHz master clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_clken  input  1  CPU clock-enable; CPU-side accesses take effect only in cycles where it is high.
REQ-005 cs  input  1  chip select for the keyboard register pair 0xD010-0xD011.
REQ-006 we  input  1  CPU write strobe; writes SHALL be ignored, with no state change.
REQ-007 address  input  1  register select: 0 = KBD data, 1 = KBDCR status.
REQ-008 dout  output  8  registered read data to the CPU data-in mux.
REQ-009 key_valid  input  1  single-cycle strobe from the upstream source (ps2keyboard or UART RX) marking a new byte.
REQ-010 key_data  input  8  byte accompanying key_valid.
REQ-011 flush  input  1  synchronous FIFO clear request.
REQ-012 key_ready  output  1  high when the FIFO is not full.
REQ-013 overflow  output  1  sticky flag: a byte was dropped.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage SHALL be DEPTH entries of 7 bits, circular, with read and write pointers wrapping modulo DEPTH.
REQ-016 Push condition: key_valid=1 and (count<DEPTH, or a pop occurs in the same cycle).
REQ-017 A pushed entry SHALL be key_data[6:0], except that 0x61-0x7A (a-z) is stored minus 0x20.
REQ-018 key_data[7] SHALL be ignored on push.
REQ-019 key_valid=1 while full with no same-cycle pop SHALL drop the byte and set overflow.
REQ-020 Pop condition: cs=1, we=0, address=0, cpu_clken=1 and count>0.
REQ-021 On a pop, dout SHALL become {1'b1, head entry} at the same edge the read pointer advances.
REQ-022 A KBD read while empty SHALL load dout=0x80 and change no pointers.
REQ-023 A KBDCR read (cs=1, we=0, address=1, cpu_clken=1) SHALL load dout={count!=0, 5'b0, overflow, count==DEPTH}.
REQ-024 The same KBDCR read SHALL clear overflow at that edge, unless a drop occurs in that same cycle, in which case overflow stays 1.
REQ-025 dout SHALL hold its value in every cycle without a qualifying read; read latency is exactly one clk25 edge.
REQ-026 Simultaneous push and pop SHALL leave count unchanged.
REQ-027 Simultaneous push and pop on an empty FIFO: the pop SHALL return 0x80 and the push SHALL be stored, giving count=1.
REQ-028 Simultaneous push and pop on a full FIFO: the pop SHALL return the head and the push SHALL be accepted, with no overflow.
REQ-029 flush=1 SHALL zero both pointers, count and overflow, with priority over push, pop and overflow set in that cycle.
REQ-030 flush SHALL leave dout unchanged.
REQ-031 key_ready SHALL equal (count!=DEPTH), combinationally from registered count.
REQ-032 overflow and count outputs SHALL be driven directly from registers.
REQ-033 The push path SHALL be independent of cpu_clken: a strobe arriving in any clk25 cycle SHALL be captured.

Reset
REQ-034 On rst=1, pointers, count and overflow SHALL be 0 and dout SHALL be 0x00, asynchronously; FIFO contents need not be cleared.
REQ-035 After rst deasserts, key_ready=1 and the first KBDCR read SHALL return 0x00.
REQ-036 Reset asserted mid-operation SHALL discard all queued bytes; no byte is delivered after reset.

Verification
REQ-037 Push 'a' (0x61) then KBD read: KBDCR=0x80 before the read, dout=0xC1 one edge after the read, count=0 after.
REQ-038 Push 9 bytes 0x31..0x39 with DEPTH=8 and no reads: count=8, key_ready=0, overflow=1, KBDCR=0x83; then 8 KBD reads return 0xB1..0xB8, 0x39 is lost, and the next KBDCR=0x00.
REQ-039 KBD read on an empty FIFO in the same cycle as key_valid with 0x0D: dout=0x80, count=1, and the next KBD read returns 0x8D.
REQ-040 FIFO full, then push 0x41 and KBD read in the same cycle: dout is the head, overflow=0, count=8, and 0x41 is last out.
REQ-041 Qualifying reads with cpu_clken=0, and writes with we=1: no pointer or dout change; flush with 3 entries queued gives count=0 and overflow=0 next edge, dout unchanged.
REQ-042 Assert rst while 5 entries are queued: count=0 and dout=0x00 immediately, without waiting for a clock edge.
